// File: rtl/fetch_pc_unit_if.sv
// Fetch/pipeline control bundle between fetch_pc_unit (master) and the surrounding pipe (slave).
interface fetch_pc_unit_if #(
  parameter int PC_BITS = 20,
  parameter int CNT_W   = 16
);
  logic               F_stall;
  logic               MEM_stall;
  logic               F_BP_taken;
  logic [PC_BITS-1:0] F_BP_target_pc;
  logic               EX_brn;
  logic [PC_BITS-1:0] EX_pc;
  logic [PC_BITS-1:0] EX_alu_out;
  logic               EX_true_taken;
  logic               EX_pred_taken;
  logic [PC_BITS-1:0] EX_pred_target;

  logic [PC_BITS-1:0] F_pc;
  logic               D_valid;
  logic [PC_BITS-1:0] D_pc;
  logic               D_pred_taken;
  logic [PC_BITS-1:0] D_pred_target;
  logic               flush_D;
  logic               flush_EX;
  logic               mispredict;
  logic [CNT_W-1:0]   br_cnt;
  logic [CNT_W-1:0]   mp_cnt;

  modport master (
    input  F_stall, MEM_stall, F_BP_taken, F_BP_target_pc,
    input  EX_brn, EX_pc, EX_alu_out, EX_true_taken, EX_pred_taken, EX_pred_target,
    output F_pc, D_valid, D_pc, D_pred_taken, D_pred_target,
    output flush_D, flush_EX, mispredict, br_cnt, mp_cnt
  );

  modport slave (
    output F_stall, MEM_stall, F_BP_taken, F_BP_target_pc,
    output EX_brn, EX_pc, EX_alu_out, EX_true_taken, EX_pred_taken, EX_pred_target,
    input  F_pc, D_valid, D_pc, D_pred_taken, D_pred_target,
    input  flush_D, flush_EX, mispredict, br_cnt, mp_cnt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC + F->D register with EX branch check and redirect; predictor lands in F_pc next cycle, redirect the cycle after resolve.
// F_stall holds F/D, MEM_stall freezes everything incl. redirect and counters; redirect beats F_stall.
module fetch_pc_unit #(
  parameter int                 PC_BITS  = 20,
  parameter logic [PC_BITS-1:0] RESET_PC = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  fetch_pc_unit_if.master bus
);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t             state, state_nxt;
  logic               act;
  logic               mis;
  logic               hold;
  logic [PC_BITS-1:0] correct_pc;

  logic [PC_BITS-1:0] f_pc_q;
  logic               d_valid_q;
  logic [PC_BITS-1:0] d_pc_q;
  logic               d_pred_taken_q;
  logic [PC_BITS-1:0] d_pred_target_q;
  logic [CNT_W-1:0]   br_q;
  logic [CNT_W-1:0]   mp_q;

  always_comb begin
    act        = bus.EX_brn & ~bus.MEM_stall;
    mis        = act & ((bus.EX_true_taken != bus.EX_pred_taken) |
                        (bus.EX_true_taken & bus.EX_pred_taken &
                         (bus.EX_alu_out != bus.EX_pred_target)));
    hold       = bus.MEM_stall | bus.F_stall;
    correct_pc = bus.EX_true_taken ? bus.EX_alu_out : bus.EX_pc + PC_BITS'(4);
  end

  // Observability only: RECOVER marks the cycle after a redirect, fetch is never gated by it.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mis) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= RUN;
      f_pc_q          <= RESET_PC;
      d_valid_q       <= 1'b0;
      d_pc_q          <= '0;
      d_pred_taken_q  <= 1'b0;
      d_pred_target_q <= '0;
      br_q            <= '0;
      mp_q            <= '0;
    end else begin
      state <= state_nxt;
      if (mis) begin
        f_pc_q          <= correct_pc;
        d_valid_q       <= 1'b0;
        d_pc_q          <= '0;
        d_pred_taken_q  <= 1'b0;
        d_pred_target_q <= '0;
      end else if (!hold) begin
        f_pc_q          <= bus.F_BP_target_pc;
        d_valid_q       <= 1'b1;
        d_pc_q          <= f_pc_q;
        d_pred_taken_q  <= bus.F_BP_taken;
        d_pred_target_q <= bus.F_BP_target_pc;
      end
      // act and mis are both low under MEM_stall, so the counters freeze with the pipe.
      if (act && (br_q != '1)) br_q <= br_q + CNT_W'(1);
      if (mis && (mp_q != '1)) mp_q <= mp_q + CNT_W'(1);
    end
  end

  assign bus.F_pc          = f_pc_q;
  assign bus.D_valid       = d_valid_q;
  assign bus.D_pc          = d_pc_q;
  assign bus.D_pred_taken  = d_pred_taken_q;
  assign bus.D_pred_target = d_pred_target_q;
  assign bus.flush_D       = mis;
  assign bus.flush_EX      = mis;
  assign bus.mispredict    = mis;
  assign bus.br_cnt        = br_q;
  assign bus.mp_cnt        = mp_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Owns the fetch PC register and the F->D pipeline register.
- Consumes the branch buffer's per-cycle prediction (F_BP_taken, F_BP_target_pc) to pick the next PC.
- Checks each branch resolved in EX against the prediction it carried down the pipe. On a mismatch it redirects fetch and squashes wrong-path instructions in D and EX.
- Keeps saturating branch and mispredict counters for performance analysis.

Parameters:
- PC_BITS, 20, byte-address PC width (word-aligned).
- RESET_PC, 0, PC loaded on reset.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low (asserted when 0).
- F_stall  in  1  decode cannot accept; hold F and D.
- MEM_stall  in  1  whole pipe frozen.
- F_BP_taken  in  1  predictor says taken for F_pc.
- F_BP_target_pc  in  PC_BITS  predictor next PC (already F_pc when stalled).
- EX_brn  in  1  instruction in EX is a valid branch.
- EX_pc  in  PC_BITS  PC of the EX branch.
- EX_alu_out  in  PC_BITS  resolved target.
- EX_true_taken  in  1  resolved direction.
- EX_pred_taken  in  1  prediction carried with the EX instruction.
- EX_pred_target  in  PC_BITS  predicted target carried with the EX instruction.
- F_pc  out  PC_BITS  current fetch PC (drives the predictor lookup and instruction memory).
- D_valid  out  1  D register holds a live instruction.
- D_pc  out  PC_BITS  PC in D.
- D_pred_taken  out  1  prediction latched with D.
- D_pred_target  out  PC_BITS  predicted next PC latched with D.
- flush_D  out  1  squash D this cycle.
- flush_EX  out  1  squash the ID/EX register on this edge.
- mispredict  out  1  combinational mispredict flag.
- br_cnt  out  CNT_W  resolved-branch count.
- mp_cnt  out  CNT_W  mispredict count.

Behaviour:
- Reset (rst=0 at edge):
  - F_pc=RESET_PC.
  - D_valid=0, D_pc=0, D_pred_taken=0, D_pred_target=0.
  - br_cnt=0, mp_cnt=0, state=RUN.
  - Reset overrides every other input, including mid-redirect.
- Mispredict check (combinational), with `act = EX_brn & ~MEM_stall`:
  - `mispredict = act & ((EX_true_taken != EX_pred_taken) | (EX_true_taken & EX_pred_taken & (EX_alu_out != EX_pred_target)))`.
- Correct PC:
  - EX_true_taken ? EX_alu_out : EX_pc+4.
  - The +4 wraps modulo 2^PC_BITS.
- Next F_pc, in priority order:
  1. mispredict -> correct PC.
  2. MEM_stall or F_stall -> hold.
  3. Otherwise -> F_BP_target_pc.
- Redirect beats F_stall.
- With MEM_stall=1, no redirect is taken. EX is frozen, so the same branch is re-evaluated once the stall clears. This guarantees exactly one redirect per branch.
- D register:
  - mispredict -> D_valid=0; other D fields don't-care, but cleared to 0.
  - Else MEM_stall or F_stall -> hold all D fields.
  - Else capture: D_valid=1, D_pc=F_pc, D_pred_taken=F_BP_taken, D_pred_target=F_BP_target_pc.
- Flush outputs:
  - flush_D = mispredict.
  - flush_EX = mispredict (the instruction in D moving to EX is wrong-path).
  - Both are one-cycle pulses, same cycle as the redirect.
- FSM:
  - States: RUN and RECOVER.
  - RUN -> RECOVER on mispredict.
  - RECOVER -> RUN after one cycle, unconditionally unless rst.
  - In RECOVER, a further mispredict input is still honoured: this is legal only for an older branch, and the pipe guarantees that does not happen. The FSM is observability only and must not gate fetch.
- Counters, updated at the clock edge:
  - br_cnt += 1 when act.
  - mp_cnt += 1 when mispredict.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - Both freeze during MEM_stall.
- Latency:
  - Predictor result appears in F_pc the next cycle.
  - Redirect appears in F_pc the cycle after the EX resolve.
  - Mispredict penalty is 2 bubbles (D and EX squashed).

Test Plan:
- Reset: rst=0 for 2 cycles with RESET_PC=0x100 -> F_pc=0x100, D_valid=0, counters 0. Release rst=1 with F_BP_target_pc=0x104 -> F_pc=0x104 next cycle; D_valid=1, D_pc=0x100.
- Correct prediction: EX_brn=1, EX_pc=0x200, pred taken to 0x240, true taken to 0x240 -> mispredict=0, no flush, br_cnt=1, mp_cnt=0, F_pc follows the predictor.
- Direction mispredict:
  - Pred not-taken, true taken to 0x300, EX_pc=0x200 -> mispredict=1, flush_D=flush_EX=1 for one cycle, F_pc=0x300 next, D_valid=0, mp_cnt=1.
  - Repeat with pred taken, true not-taken -> F_pc=0x204.
- Target mispredict: pred taken 0x240, true taken 0x280 -> redirect to 0x280.
- Stall interaction:
  - Mispredict with F_stall=1 -> redirect still taken.
  - Same branch with MEM_stall=1 for 3 cycles -> no redirect, F_pc and D held, counters frozen; after release, exactly one redirect, mp_cnt +1.
- Wrap and saturation:
  - EX_pc=0xFFFFC, true not-taken, pred taken -> F_pc=0x00000.
  - CNT_W=4 with 20 mispredicts -> mp_cnt=15 and holds there.
